// File: rtl/semafor_numarator.sv
// Traffic-light phase sequencer with per-phase seconds countdown.
// Pedestrian request latches and cuts the green phase short.
module semafor_numarator #(
  parameter int latime     = 6,
  parameter int sec_verde  = 10,
  parameter int sec_galben = 3,
  parameter int sec_rosu   = 12,
  parameter int sec_min    = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable,
  input  logic              puls_1_sec,
  input  logic              cerere_pieton,
  output logic [latime-1:0] secunde,
  output logic [2:0]        lumini,
  output logic [1:0]        stare,
  output logic              schimbare_faza,
  output logic              cerere_activa
);

  typedef enum logic [1:0] {
    VERDE  = 2'b00,
    GALBEN = 2'b01,
    ROSU   = 2'b10
  } faza_t;

  localparam logic [latime-1:0] LD_V = latime'(sec_verde - 1);
  localparam logic [latime-1:0] LD_G = latime'(sec_galben - 1);
  localparam logic [latime-1:0] LD_R = latime'(sec_rosu - 1);
  localparam logic [latime-1:0] SMIN = latime'(sec_min);
  localparam logic [latime-1:0] ONE  = latime'(1);

  faza_t             st_q, st_d;
  logic [latime-1:0] sec_q, sec_d;
  logic [2:0]        lum_q, lum_d;
  logic              req_q, req_d;
  logic              chg_q, chg_d;
  logic              tick, zero, cerere;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      st_q  <= ROSU;
      sec_q <= LD_R;
      lum_q <= 3'b100;
      req_q <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      sec_q <= sec_d;
      lum_q <= lum_d;
      req_q <= req_d;
      chg_q <= chg_d;
    end
  end

  always_comb begin
    tick   = enable & puls_1_sec;
    zero   = (sec_q == '0);
    cerere = req_q | cerere_pieton;
    st_d   = st_q;
    sec_d  = sec_q;
    chg_d  = 1'b0;
    req_d  = cerere;
    if (tick) begin
      if (zero) begin
        chg_d = 1'b1;
        unique case (st_q)
          VERDE: begin
            st_d  = GALBEN;
            sec_d = LD_G;
          end
          GALBEN: begin
            st_d  = ROSU;
            sec_d = LD_R;
            // entering red serves the request; wins over a new one
            req_d = 1'b0;
          end
          default: begin
            st_d  = VERDE;
            sec_d = LD_V;
          end
        endcase
      end else if (st_q == VERDE && cerere && sec_q > SMIN) begin
        sec_d = SMIN;
      end else begin
        sec_d = sec_q - ONE;
      end
    end
    unique case (1'b1)
      st_d == VERDE:  lum_d = 3'b001;
      st_d == GALBEN: lum_d = 3'b010;
      default:        lum_d = 3'b100;
    endcase
  end

  always_comb begin
    stare          = st_q;
    secunde        = sec_q;
    lumini         = lum_q;
    cerere_activa  = req_q;
    schimbare_faza = chg_q;
  end

endmodule
